// File: rtl/coef_loader.sv
// Converts a 5-digit signed BCD entry into a W-bit coefficient slot.
// Define COEF_BCD_CHECK_EN to reject entries containing non-BCD digits.
module coef_loader #(
  parameter  int NCOEF = 4,
  parameter  int W     = 18,
  localparam int SW    = (NCOEF > 1) ? $clog2(NCOEF) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_req,
  input  logic [19:0]        digits,
  input  logic               neg,
  input  logic [SW-1:0]      slot,
  input  logic               clear,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [NCOEF*W-1:0] coef_flat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [2:0]      idx_q, idx_d;
  logic [19:0]     dig_q, dig_d;
  logic            neg_q, neg_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            wr_en, clr;
  logic            slot_ok;
  logic [3:0]      cur;
  logic [W-1:0]    acc_mac;
  logic [W-1:0]    wr_val;
  logic [W-1:0]    coef_q [NCOEF];

  assign slot_ok = int'(slot) < NCOEF;
  assign cur     = dig_q[{idx_q, 2'b00} +: 4];
  // acc*10 as shift-add, wrapping modulo 2^W
  assign acc_mac = (acc_q << 3) + (acc_q << 1) + W'(cur);
  assign wr_val  = neg_q ? -acc_q : acc_q;

`ifdef COEF_BCD_CHECK_EN
  logic err_q, err_d;
  logic bcd_bad;

  always_comb begin
    bcd_bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (dig_q[4*k +: 4] > 4'd9) bcd_bad = 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    dig_d   = dig_q;
    neg_d   = neg_q;
    slot_d  = slot_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    clr     = 1'b0;
`ifdef COEF_BCD_CHECK_EN
    err_d   = err_q;
`endif
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      busy_d  = 1'b0;
      clr     = 1'b1;
`ifdef COEF_BCD_CHECK_EN
      err_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_req && slot_ok) begin
            dig_d   = digits;
            neg_d   = neg;
            slot_d  = slot;
            acc_d   = '0;
            idx_d   = 3'd4;
            busy_d  = 1'b1;
            state_d = CONV;
`ifdef COEF_BCD_CHECK_EN
            err_d   = 1'b0;
`endif
          end
        end
        CONV: begin
          acc_d = acc_mac;
          idx_d = idx_q - 3'd1;
          if (idx_q == 3'd0) state_d = WRITE;
`ifdef COEF_BCD_CHECK_EN
          // invalid entry aborts on the first conversion edge
          if (idx_q == 3'd4 && bcd_bad) begin
            acc_d   = acc_q;
            idx_d   = idx_q;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            state_d = IDLE;
          end
`endif
        end
        WRITE: begin
          wr_en   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      neg_q   <= 1'b0;
      slot_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      neg_q   <= neg_d;
      slot_q  <= slot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef COEF_BCD_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NCOEF; k++) coef_q[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < NCOEF; k++) coef_q[k] <= '0;
    end else if (wr_en) begin
      coef_q[slot_q] <= wr_val;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  for (genvar g = 0; g < NCOEF; g++) begin : g_flat
    assign coef_flat[g*W +: W] = coef_q[g];
  end

endmodule
